// File: rtl/soc_irq_pkg.sv
// Shared definitions for the SoC interrupt controller: register map and
// request/service handshake states.
package soc_irq_pkg;

   localparam logic [1:0] IRQ_REG_MASK = 2'd0;
   localparam logic [1:0] IRQ_REG_EDGE = 2'd1;
   localparam logic [1:0] IRQ_REG_PEND = 2'd2;
   localparam logic [1:0] IRQ_REG_STAT = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      SERVICE
   } irq_state_t;

endpackage

// File: rtl/irq_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous level inputs.
module irq_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [STAGES];

   // Shift the raw inputs through STAGES flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < STAGES; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= din;
         for (int unsigned i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/soc_irq_ctrl.sv
// Interrupt controller: synchronises the external lines, captures them as
// level or edge, masks them and hands the lowest pending index to the CPU
// through a req/ack/eoi handshake. A small register port exposes
// MASK, EDGE, PENDING (W1C for edge lines) and STATUS.
module soc_irq_ctrl
   import soc_irq_pkg::*;
#(
   parameter  int IRQ_LINES   = 4,
   parameter  int SYNC_STAGES = 2,
   localparam int ID_W        = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IRQ_LINES-1:0] irq_lines,
   output logic                 irq_req,
   output logic [ID_W-1:0]      irq_id,
   input  logic                 irq_ack,
   input  logic                 irq_eoi,
   input  logic                 cfg_we,
   input  logic [1:0]           cfg_addr,
   input  logic [IRQ_LINES-1:0] cfg_wdata,
   output logic [IRQ_LINES-1:0] cfg_rdata
);

   irq_state_t           state_q;
   logic [ID_W-1:0]      service_id_q;
   logic [IRQ_LINES-1:0] sync_q;
   logic [IRQ_LINES-1:0] prev_q;
   logic [IRQ_LINES-1:0] mask_q;
   logic [IRQ_LINES-1:0] edge_q;
   logic [IRQ_LINES-1:0] latch_q;
   logic [IRQ_LINES-1:0] latch_d;
   logic [IRQ_LINES-1:0] pending;
   logic [IRQ_LINES-1:0] svc_onehot;
   logic [IRQ_LINES-1:0] eligible;
   logic [ID_W-1:0]      winner;
   logic                 any_elig;
   logic                 in_service;
   logic                 ack_take;
   logic                 we_pend;
   logic                 we_edge;

   irq_sync #(
      .WIDTH  (IRQ_LINES),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (irq_lines),
      .dout (sync_q)
   );

   assign in_service = (state_q == SERVICE);
   assign ack_take   = (state_q == REQ) && irq_ack;
   assign we_pend    = cfg_we && (cfg_addr == IRQ_REG_PEND);
   assign we_edge    = cfg_we && (cfg_addr == IRQ_REG_EDGE);

   // Edge lines show their latched bit, level lines show the live synced level.
   assign pending  = (edge_q & latch_q) | (~edge_q & sync_q);
   assign eligible = pending & mask_q & ~svc_onehot;

   // One-hot of the line currently in service, excluded from arbitration.
   always_comb begin
      svc_onehot = '0;
      for (int unsigned i = 0; i < IRQ_LINES; i++) begin
         if (in_service && (service_id_q == ID_W'(i))) svc_onehot[i] = 1'b1;
      end
   end

   // Fixed priority: lowest eligible index wins.
   always_comb begin
      winner   = '0;
      any_elig = 1'b0;
      for (int unsigned i = 0; i < IRQ_LINES; i++) begin
         if (eligible[i] && !any_elig) begin
            winner   = ID_W'(i);
            any_elig = 1'b1;
         end
      end
   end

   // Next edge-latch value: clears first, a new rising edge overrides them,
   // and a mode change on a line always discards its latched bit.
   always_comb begin
      latch_d = latch_q;
      if (we_pend) latch_d = latch_d & ~cfg_wdata;
      for (int unsigned i = 0; i < IRQ_LINES; i++) begin
         if (ack_take && (irq_id == ID_W'(i))) latch_d[i] = 1'b0;
      end
      latch_d = latch_d | (edge_q & sync_q & ~prev_q);
      if (we_edge) latch_d = latch_d & ~(cfg_wdata ^ edge_q);
   end

   // Configuration registers, edge history and edge latches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q  <= '0;
         edge_q  <= '0;
         latch_q <= '0;
         prev_q  <= '0;
      end else begin
         prev_q  <= sync_q;
         latch_q <= latch_d;
         if (cfg_we && (cfg_addr == IRQ_REG_MASK)) mask_q <= cfg_wdata;
         if (we_edge) edge_q <= cfg_wdata;
      end
   end

   // Request/ack/eoi handshake with registered request outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         irq_req      <= 1'b0;
         irq_id       <= '0;
         service_id_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_elig) begin
                  irq_req <= 1'b1;
                  irq_id  <= winner;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (irq_ack) begin
                  service_id_q <= irq_id;
                  irq_req      <= 1'b0;
                  state_q      <= SERVICE;
               end else if (!any_elig) begin
                  irq_req <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  irq_id <= winner;
               end
            end
            SERVICE: begin
               if (irq_eoi) begin
                  service_id_q <= '0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               irq_req <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Register read mux; STATUS packs {service_id, in_service} into the low bits.
   always_comb begin
      case (cfg_addr)
         IRQ_REG_MASK: cfg_rdata = mask_q;
         IRQ_REG_EDGE: cfg_rdata = edge_q;
         IRQ_REG_PEND: cfg_rdata = pending;
         default:      cfg_rdata = IRQ_LINES'({service_id_q, in_service});
      endcase
   end

endmodule

// File: tb/tb_soc_irq_ctrl.sv
// Self-checking bench for soc_irq_ctrl: directed scenarios followed by a
// randomized run, all compared against a cycle-level behavioural model.
module tb_soc_irq_ctrl;

   localparam int N = 4;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] irq_lines = '1;
   logic         irq_req;
   logic [1:0]   irq_id;
   logic         irq_ack = 1'b0;
   logic         irq_eoi = 1'b0;
   logic         cfg_we = 1'b0;
   logic [1:0]   cfg_addr = '0;
   logic [N-1:0] cfg_wdata = '0;
   logic [N-1:0] cfg_rdata;

   int checks = 0;
   int errors = 0;

   soc_irq_ctrl #(
      .IRQ_LINES   (N),
      .SYNC_STAGES (S)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .irq_lines (irq_lines),
      .irq_req   (irq_req),
      .irq_id    (irq_id),
      .irq_ack   (irq_ack),
      .irq_eoi   (irq_eoi),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Line history: each entry is the value of irq_lines seen at one clock
   // edge; the synchronised view is simply that history delayed S-1 edges.
   bit [N-1:0] hist[$];
   bit [N-1:0] m_mask, m_edge, m_latch;
   bit         m_req, m_busy;
   bit [1:0]   m_id, m_svc;

   function automatic bit [N-1:0] sync_val(int back);
      return hist[hist.size() - S - back];
   endfunction

   function automatic bit [N-1:0] m_pending();
      return (m_edge & m_latch) | (~m_edge & sync_val(0));
   endfunction

   function automatic bit [N-1:0] exp_rdata(bit [1:0] a);
      case (a)
         2'd0:    return m_mask;
         2'd1:    return m_edge;
         2'd2:    return m_pending();
         default: return m_busy ? {1'b0, m_svc, 1'b1} : 4'h0;
      endcase
   endfunction

   task automatic model_reset();
      hist.delete();
      repeat (S + 1) hist.push_back('0);
      m_mask = '0; m_edge = '0; m_latch = '0;
      m_req = 0; m_busy = 0; m_id = '0; m_svc = '0;
   endtask

   task automatic model_step();
      bit [N-1:0] s, sp, elig, rise;
      int         win;
      bit         ack_ok, eoi_ok;
      s    = sync_val(0);
      sp   = sync_val(1);
      rise = s & ~sp;
      elig = m_pending() & m_mask;
      if (m_busy) elig[m_svc] = 1'b0;
      win = -1;
      for (int i = N - 1; i >= 0; i--) if (elig[i]) win = i;
      ack_ok = m_req && irq_ack;
      eoi_ok = m_busy && irq_eoi;
      // edge latches: clears, then a fresh rising edge wins, mode change discards
      if (cfg_we && cfg_addr == 2'd2) m_latch &= ~cfg_wdata;
      if (ack_ok) m_latch[m_id] = 1'b0;
      m_latch |= m_edge & rise;
      if (cfg_we && cfg_addr == 2'd1) m_latch &= ~(cfg_wdata ^ m_edge);
      // handshake
      if (m_req) begin
         if (ack_ok) begin m_req = 0; m_busy = 1; m_svc = m_id; end
         else if (win < 0) m_req = 0;
         else m_id = 2'(win);
      end else if (m_busy) begin
         if (eoi_ok) begin m_busy = 0; m_svc = '0; end
      end else if (win >= 0) begin
         m_req = 1; m_id = 2'(win);
      end
      if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata;
      if (cfg_we && cfg_addr == 2'd1) m_edge = cfg_wdata;
      hist.push_back(irq_lines);
      if (hist.size() > 16) void'(hist.pop_front());
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("model_req", 32'(irq_req), 32'(m_req));
      if (m_req) chk("model_id", 32'(irq_id), 32'(m_id));
      chk("model_rdata", 32'(cfg_rdata), 32'(exp_rdata(cfg_addr)));
   endtask

   // One clock edge: advance the model, then compare on the falling edge.
   task automatic cyc();
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic rd(input bit [1:0] a, input string tag, input bit [N-1:0] exp);
      cfg_addr = a;
      #1;
      chk(tag, 32'(cfg_rdata), 32'(exp));
   endtask

   task automatic wr(input bit [1:0] a, input bit [N-1:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      cyc();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_ack();
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
   endtask

   task automatic pulse_eoi();
      irq_eoi = 1'b1; cyc(); irq_eoi = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      @(negedge clk);

      // Reset with all lines high
      repeat (3) cyc();
      for (int a = 0; a < 4; a++) rd(2'(a), "rst_rdata", '0);
      chk("rst_req", 32'(irq_req), 0);
      chk("rst_id", 32'(irq_id), 0);
      rst = 1'b0;
      repeat (5) cyc();
      chk("nomask_req", 32'(irq_req), 0);

      // Edge capture on line 2
      irq_lines = '0;
      repeat (3) cyc();
      wr(2'd0, 4'hF);
      wr(2'd1, 4'h4);
      irq_lines = 4'h4;
      cyc();
      irq_lines = '0;
      chk("edge_req_k", 32'(irq_req), 0);
      cyc();
      cyc();
      rd(2'd2, "edge_pend", 4'h4);
      chk("edge_req_early", 32'(irq_req), 0);
      cyc();
      chk("edge_req", 32'(irq_req), 1);
      chk("edge_id", 32'(irq_id), 2);
      pulse_ack();
      chk("ack_req", 32'(irq_req), 0);
      rd(2'd2, "ack_pend", 4'h0);
      rd(2'd3, "ack_stat", 4'h5);
      pulse_eoi();
      rd(2'd3, "eoi_stat", 4'h0);

      // Priority between level lines 1 and 3
      wr(2'd1, 4'h0);
      irq_lines = 4'b1010;
      repeat (3) cyc();
      chk("prio_req", 32'(irq_req), 1);
      chk("prio_id", 32'(irq_id), 1);
      irq_lines = 4'b1000;
      pulse_ack();
      rd(2'd3, "prio_stat", 4'h3);
      pulse_eoi();
      repeat (2) cyc();
      chk("prio_next_req", 32'(irq_req), 1);
      chk("prio_next_id", 32'(irq_id), 3);
      irq_lines = '0;
      pulse_ack();
      pulse_eoi();
      repeat (2) cyc();
      chk("prio_clean", 32'(irq_req), 0);

      // Preemption while requesting
      irq_lines = 4'b1000;
      repeat (3) cyc();
      chk("pre_id3", 32'(irq_id), 3);
      irq_lines = 4'b1001;
      cyc();
      chk("pre_hold1", 32'(irq_req), 1);
      cyc();
      chk("pre_hold2", 32'(irq_req), 1);
      chk("pre_still3", 32'(irq_id), 3);
      cyc();
      chk("pre_hold3", 32'(irq_req), 1);
      chk("pre_id0", 32'(irq_id), 0);
      irq_lines = '0;
      pulse_ack();
      pulse_eoi();
      repeat (2) cyc();

      // Withdrawal by masking, then a stray ack
      irq_lines = 4'h4;
      repeat (3) cyc();
      chk("wd_req_on", 32'(irq_req), 1);
      chk("wd_id", 32'(irq_id), 2);
      wr(2'd0, 4'h0);
      chk("wd_req_n", 32'(irq_req), 1);
      cyc();
      chk("wd_req_off", 32'(irq_req), 0);
      pulse_ack();
      chk("wd_stray_req", 32'(irq_req), 0);
      rd(2'd3, "wd_stat", 4'h0);
      irq_lines = '0;
      repeat (3) cyc();
      wr(2'd0, 4'hF);

      // Level retrigger, then reset in SERVICE
      irq_lines = 4'h1;
      repeat (3) cyc();
      chk("rt_req", 32'(irq_req), 1);
      chk("rt_id", 32'(irq_id), 0);
      pulse_ack();
      pulse_eoi();
      chk("rt_req_eoi", 32'(irq_req), 0);
      cyc();
      chk("rt_rereq", 32'(irq_req), 1);
      chk("rt_reid", 32'(irq_id), 0);
      pulse_ack();
      rd(2'd3, "rt_stat", 4'h1);
      rst = 1'b1;
      #1;
      chk("arst_req", 32'(irq_req), 0);
      chk("arst_id", 32'(irq_id), 0);
      rd(2'd3, "arst_stat", 4'h0);
      rd(2'd2, "arst_pend", 4'h0);
      model_reset();
      cyc();
      rst = 1'b0;
      cyc();

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 3) == 0) irq_lines = N'($urandom);
         irq_ack   = ($urandom_range(0, 3) == 0);
         irq_eoi   = ($urandom_range(0, 3) == 0);
         cfg_we    = ($urandom_range(0, 5) == 0);
         cfg_addr  = 2'($urandom);
         cfg_wdata = N'($urandom);
         cyc();
      end
      irq_ack = 1'b0; irq_eoi = 1'b0; cfg_we = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
